// File: rtl/int_controller.sv
// ---------------------------------------------------------------------------
// int_controller
//   Four-line, rising-edge-sensitive interrupt controller. Latches edges into
//   pending bits, arbitrates the lowest enabled pending line, raises a
//   registered request with its vector address, and tracks the handler
//   through acknowledge and return-from-interrupt. There is no nesting: while
//   a handler runs, new edges only accumulate as pending bits.
//
//   Optional feature: define INT_MASK_EN to get a writable 4-bit enable mask.
//   Without it the mask is fixed at 4'b1111, and mask_we/mask_wdata are
//   accepted but have no effect.
//
// Parameters
//   VEC_BASE    vector address of IRQ line 0
//   VEC_STRIDE  address spacing between consecutive vectors
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-low reset
//   irq_in[3:0]  in   external interrupt lines (rising-edge sensitive)
//   stall        in   blocks issue of a new request while high
//   int_ack      in   jump/control block has taken the interrupt
//   reti         in   return-from-interrupt decoded
//   mask_we      in   mask write strobe (INT_MASK_EN only)
//   mask_wdata   in   mask write data, bit i = 1 enables line i
//   int_req      out  registered interrupt request
//   int_vec      out  jump address of the selected line
//   int_id       out  index of the selected line
//   pending      out  latched pending bits
//   in_service   out  high while a handler is executing
// ---------------------------------------------------------------------------
module int_controller #(
  parameter logic [15:0] VEC_BASE   = 16'h0100,
  parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_in,
  input  logic        stall,
  input  logic        int_ack,
  input  logic        reti,
  input  logic        mask_we,
  input  logic [3:0]  mask_wdata,
  output logic        int_req,
  output logic [15:0] int_vec,
  output logic [1:0]  int_id,
  output logic [3:0]  pending,
  output logic        in_service
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_SERVICE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_irq_q;
  logic [3:0]  r_pending;
  logic        r_int_req;
  logic [1:0]  r_int_id;
  logic [15:0] r_int_vec;
  logic        r_in_service;

  logic [3:0]  w_mask;
  logic [3:0]  w_rise;
  logic [3:0]  w_ack_clr;
  logic [3:0]  w_pending_nxt;
  logic [3:0]  w_eligible;
  logic [1:0]  w_sel_id;

  // Vector address; arithmetic is done at 16 bits so it wraps on overflow.
  function automatic logic [15:0] vec_of(input logic [1:0] id);
    return VEC_BASE + 16'(id) * VEC_STRIDE;
  endfunction

`ifdef INT_MASK_EN
  logic [3:0] r_mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_mask <= 4'b1111;
    else if (mask_we)
      r_mask <= mask_wdata;
  end

  assign w_mask = r_mask;
`else
  // Mask write port exists for interface compatibility only.
  logic w_unused_mask;
  assign w_unused_mask = &{1'b0, mask_we, mask_wdata};
  assign w_mask        = 4'b1111;
`endif

  // A line held high across reset release sees r_irq_q = 0 and so counts
  // as a rising edge on the first clock.
  assign w_rise = irq_in & ~r_irq_q;

  // Acknowledge clears the serviced line, but a fresh edge on that same line
  // in the same cycle is OR-ed back in afterwards and wins.
  assign w_ack_clr     = (r_state == ST_REQUEST && int_ack) ? (4'b0001 << r_int_id) : 4'b0000;
  assign w_pending_nxt = (r_pending & ~w_ack_clr) | w_rise;

  assign w_eligible = r_pending & w_mask;

  // Lowest index wins: scan from the top so lower indices overwrite.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sel_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_eligible[i])
        w_sel_id = 2'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_irq_q      <= 4'b0000;
      r_pending    <= 4'b0000;
      r_int_req    <= 1'b0;
      r_int_id     <= 2'd0;
      r_int_vec    <= VEC_BASE;
      r_in_service <= 1'b0;
    end else begin
      r_irq_q   <= irq_in;
      r_pending <= w_pending_nxt;

      unique case (r_state)
        ST_IDLE: begin
          if (w_eligible != 4'b0000 && !stall) begin
            r_int_id  <= w_sel_id;
            r_int_vec <= vec_of(w_sel_id);
            r_int_req <= 1'b1;
            r_state   <= ST_REQUEST;
          end
        end
        // int_id/int_vec are frozen here; stall has no effect once issued.
        ST_REQUEST: begin
          if (int_ack) begin
            r_int_req    <= 1'b0;
            r_in_service <= 1'b1;
            r_state      <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (reti) begin
            r_in_service <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign int_req    = r_int_req;
  assign int_vec    = r_int_vec;
  assign int_id     = r_int_id;
  assign pending    = r_pending;
  assign in_service = r_in_service;

endmodule

// File: tb/tb_int_controller.sv
// ---------------------------------------------------------------------------
// tb_int_controller
//   Self-checking bench for int_controller. Expected grants (line id) are
//   pushed to a scoreboard queue when the stimulus is driven and popped when
//   the DUT raises int_req; the expected vector is recomputed from the id.
//   Inputs change 1 ns after the rising edge and are sampled there too.
// ---------------------------------------------------------------------------
module tb_int_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_in;
  logic        stall;
  logic        int_ack;
  logic        reti;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        int_req;
  logic [15:0] int_vec;
  logic [1:0]  int_id;
  logic [3:0]  pending;
  logic        in_service;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  logic [1:0] sb_q[$];

  int_controller #(
    .VEC_BASE  (16'h0100),
    .VEC_STRIDE(16'h0010)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .stall     (stall),
    .int_ack   (int_ack),
    .reti      (reti),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .int_req   (int_req),
    .int_vec   (int_vec),
    .int_id    (int_id),
    .pending   (pending),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for int_req, then pops the scoreboard and compares.
  task automatic wait_grant(input string tag, input int max_cycles, output int cycles);
    logic [1:0]  exp_id;
    logic [15:0] exp_vec;
    cycles = 0;
    while (int_req !== 1'b1 && cycles < max_cycles) begin
      tick();
      cycles++;
    end
    check({tag, "_req"}, int_req, 1'b1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb_q.size()), 1);
    end else begin
      exp_id  = sb_q.pop_front();
      exp_vec = 16'h0100 + 16'(exp_id) * 16'h0010;
      check({tag, "_id"}, int_id, exp_id);
      check({tag, "_vec"}, int_vec, exp_vec);
    end
  endtask

  task automatic do_ack(input string tag);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check({tag, "_ack_req"}, int_req, 1'b0);
    check({tag, "_ack_insvc"}, in_service, 1'b1);
  endtask

  task automatic do_reti(input string tag);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    check({tag, "_reti_insvc"}, in_service, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; irq_in = 4'b0100; stall = 1'b0; int_ack = 1'b0;
    reti = 1'b0; mask_we = 1'b0; mask_wdata = 4'b0000;

    // Reset state, with line 2 already high across reset.
    #12;
    check("rst_req", int_req, 1'b0);
    check("rst_id", int_id, 2'd0);
    check("rst_vec", int_vec, 16'h0100);
    check("rst_pend", pending, 4'b0000);
    check("rst_insvc", in_service, 1'b0);
    reset = 1'b1;

    // Line held high through reset counts as an edge on the first clock.
    tick();
    check("t1_pend", pending, 4'b0100);
    check("t1_req0", int_req, 1'b0);
    sb_q.push_back(2'd2);
    wait_grant("t1", 3, lat);
    check("t1_lat", lat, 1);
    do_ack("t1");
    check("t1_pend_clr", pending, 4'b0000);
    irq_in = 4'b0000;
    do_reti("t1");

    // Simultaneous edges: lowest first, then back-to-back after reti.
    tick();
    irq_in = 4'b1010;
    sb_q.push_back(2'd1);
    sb_q.push_back(2'd3);
    tick();
    check("t2_pend", pending, 4'b1010);
    wait_grant("t2a", 3, lat);
    check("t2a_lat", lat, 1);
    do_ack("t2a");
    check("t2_pend_after_ack", pending, 4'b1000);
    do_reti("t2a");
    check("t2_req_after_reti", int_req, 1'b0);
    wait_grant("t2b", 3, lat);
    check("t2b_lat", lat, 1);
    do_ack("t2b");
    do_reti("t2b");
    irq_in = 4'b0000;

    // Stall blocks issue; once issued, stall does not drop the request.
    stall = 1'b1;
    tick();
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    repeat (3) tick();
    check("t3_stall_req", int_req, 1'b0);
    check("t3_stall_pend", pending, 4'b0001);
    stall = 1'b0;
    sb_q.push_back(2'd0);
    wait_grant("t3", 3, lat);
    check("t3_lat", lat, 1);
    stall = 1'b1;
    tick();
    check("t3_req_hold", int_req, 1'b1);
    check("t3_id_hold", int_id, 2'd0);
    stall = 1'b0;
    do_ack("t3");

    // New edge on line 0 while its handler runs: no nesting until reti.
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    repeat (2) tick();
    check("t4_svc_req", int_req, 1'b0);
    check("t4_svc_pend", pending, 4'b0001);
    check("t4_svc_insvc", in_service, 1'b1);
    do_reti("t4");
    check("t4_req_after_reti", int_req, 1'b0);
    sb_q.push_back(2'd0);
    wait_grant("t4", 3, lat);
    check("t4_lat", lat, 1);
    do_ack("t4");
    do_reti("t4");

    // Edge on the acknowledged line in the ack cycle keeps pending set.
    irq_in = 4'b0010;
    tick();
    irq_in = 4'b0000;
    sb_q.push_back(2'd1);
    wait_grant("t5", 3, lat);
    tick();
    int_ack = 1'b1;
    irq_in  = 4'b0010;
    tick();
    int_ack = 1'b0;
    irq_in  = 4'b0000;
    check("t5_pend_kept", pending, 4'b0010);
    check("t5_insvc", in_service, 1'b1);
    do_reti("t5");
    sb_q.push_back(2'd1);
    wait_grant("t5b", 3, lat);
    do_ack("t5b");
    check("t5b_pend", pending, 4'b0000);
    do_reti("t5b");

    // reti and int_ack in IDLE are ignored.
    reti = 1'b1; int_ack = 1'b1;
    tick();
    reti = 1'b0; int_ack = 1'b0;
    check("t6_idle_req", int_req, 1'b0);
    check("t6_idle_insvc", in_service, 1'b0);

    // Mask behaviour.
    mask_we = 1'b1; mask_wdata = 4'b1110;
    tick();
    mask_we = 1'b0;
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
`ifdef INT_MASK_EN
    repeat (2) tick();
    check("t7_mask_pend", pending, 4'b0001);
    check("t7_mask_req", int_req, 1'b0);
    mask_we = 1'b1; mask_wdata = 4'b1111;
    tick();
    mask_we = 1'b0;
`else
    check("t7_pend", pending, 4'b0001);
`endif
    sb_q.push_back(2'd0);
    wait_grant("t7", 3, lat);
    check("t7_lat", lat, 1);
    // reti while in REQUEST is ignored.
    reti = 1'b1;
    tick();
    reti = 1'b0;
    check("t7_reti_req", int_req, 1'b1);
    check("t7_reti_insvc", in_service, 1'b0);
    do_ack("t7");
    do_reti("t7");

    // Asynchronous reset in the middle of SERVICE.
    irq_in = 4'b0011;
    tick();
    irq_in = 4'b0000;
    sb_q.push_back(2'd0);
    wait_grant("t8", 3, lat);
    do_ack("t8");
    check("t8_pend_before", pending, 4'b0010);
    #2;
    reset = 1'b0;
    #1;
    check("t8_async_insvc", in_service, 1'b0);
    check("t8_async_pend", pending, 4'b0000);
    check("t8_async_req", int_req, 1'b0);
    check("t8_async_vec", int_vec, 16'h0100);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    check("t8_post_req", int_req, 1'b0);
    check("t8_post_pend", pending, 4'b0000);

    check("sb_drain", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
